// File: rtl/bios_pkg.sv
// Shared BIOS definitions: UART receive FSM states and the default bit timing.
package bios_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Head is forced to zero when empty so o_rdata has a defined reset value.
  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver feeding a byte stream (valid/ready) to the BIOS command
// dispatcher through a small FIFO; reports framing errors and overruns as pulses.
module uart_rx_stream
  import bios_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic           rxd_meta_q, rxd_s_q;
  uart_rx_state_t state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           frame_err_q, overrun_q;

  logic cnt_zero, byte_push, fifo_pop, fifo_full, fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign cnt_zero  = (cnt_q == '0);
  assign byte_push = (state_q == STOP) && cnt_zero && rxd_s_q;
  assign fifo_pop  = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= byte_push & fifo_full & ~fifo_pop;
      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
          end
        end
        START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (!rxd_s_q) begin
            state_q   <= DATA;
            cnt_q     <= CNT_FULL;
            bit_idx_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q   <= {rxd_s_q, shift_q[7:1]};
            cnt_q     <= CNT_FULL;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rxd_s_q) begin
            state_q <= IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) yields only the single error already flagged.
          if (rxd_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (byte_push),
    .i_wdata (shift_q),
    .o_full  (fifo_full),
    .i_pop   (fifo_pop),
    .o_rdata (o_data),
    .o_empty (fifo_empty)
  );

  assign o_valid     = ~fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_stream;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rxd = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = 0;
  int s0, s1, s2;

  logic [7:0] rx_q[$];
  int         rise_q[$];
  int         fe_cnt = 0, ov_cnt = 0, dbl_cnt = 0;
  logic       prev_v = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

  uart_rx_stream #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (o_valid === 1'b1 && prev_v !== 1'b1) rise_q.push_back(cyc);
    if (o_valid === 1'b1 && i_ready === 1'b1) rx_q.push_back(o_data);
    if (o_frame_err === 1'b1) fe_cnt++;
    if (o_overrun === 1'b1) ov_cnt++;
    if ((o_frame_err === 1'b1 && prev_fe === 1'b1) ||
        (o_overrun === 1'b1 && prev_ov === 1'b1)) dbl_cnt++;
    prev_v  = o_valid;
    prev_fe = o_frame_err;
    prev_ov = o_overrun;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    rise_q.delete();
    fe_cnt  = 0;
    ov_cnt  = 0;
    dbl_cnt = 0;
  endtask

  // Drives one 8N1 frame; optionally raises i_ready or rst after a given number of cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int ready_at, input int rst_at);
    logic [9:0] fr;
    int n;
    fr = {stop_bit, b, 1'b0};
    last_start = cyc;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      i_rxd = fr[i];
      for (int j = 0; j < CPB; j++) begin
        tick();
        n++;
        if (n == ready_at) i_ready = 1'b1;
        if (n == rst_at) rst = 1'b1;
      end
    end
    i_rxd = 1'b1;
  endtask

  function automatic logic [39:0] pack_rx();
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      r = {r[31:0], (i < rx_q.size()) ? rx_q[i] : 8'hEE};
    return r;
  endfunction

  function automatic int rise_lat(input int idx, input int start);
    return (idx < rise_q.size()) ? rise_q[idx] - start : -1;
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // Back-to-back bytes with the sink always ready; valid rises 155 cycles after line fall
    i_ready = 1'b1;
    clear_obs();
    send_byte(8'h04, 1'b1, -1, -1); s0 = last_start;
    send_byte(8'h41, 1'b1, -1, -1); s1 = last_start;
    send_byte(8'h00, 1'b1, -1, -1); s2 = last_start;
    repeat (4) tick();
    check("b2b_count", rx_q.size(), 3);
    check("b2b_data", pack_rx(), {8'h04, 8'h41, 8'h00, 8'hEE, 8'hEE});
    check("b2b_lat0", rise_lat(0, s0), 155);
    check("b2b_lat1", rise_lat(1, s1), 155);
    check("b2b_lat2", rise_lat(2, s2), 155);
    check("b2b_ferr", fe_cnt, 0);
    check("b2b_ovr", ov_cnt, 0);

    // 5-cycle low glitch is a false start
    clear_obs();
    i_rxd = 1'b0;
    repeat (5) tick();
    i_rxd = 1'b1;
    check("glitch_busy", o_busy, 1'b1);
    repeat (20) tick();
    check("glitch_idle", o_busy, 1'b0);
    check("glitch_valid", o_valid, 1'b0);
    check("glitch_ferr", fe_cnt, 0);

    // Framing error on 0x55, then a clean 0xA5
    clear_obs();
    send_byte(8'h55, 1'b0, -1, -1);
    repeat (16) tick();
    check("ferr_pulse", fe_cnt, 1);
    check("ferr_nopush", rx_q.size(), 0);
    check("ferr_valid", o_valid, 1'b0);
    check("ferr_idle", o_busy, 1'b0);
    send_byte(8'hA5, 1'b1, -1, -1);
    repeat (4) tick();
    check("ferr_next", pack_rx(), {8'hA5, 8'hEE, 8'hEE, 8'hEE, 8'hEE});
    check("ferr_once", fe_cnt, 1);

    // Overrun: five bytes into a 4-deep FIFO with the sink stalled
    clear_obs();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1, -1, -1);
    repeat (2) tick();
    check("ovr_pulse", ov_cnt, 1);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_head", o_data, 8'h01);
    i_ready = 1'b1;
    repeat (8) tick();
    check("ovr_drain", pack_rx(), {8'h01, 8'h02, 8'h03, 8'h04, 8'hEE});
    check("ovr_empty", o_valid, 1'b0);
    check("ovr_single", dbl_cnt, 0);

    // Full FIFO, but a pop coincides with the 5th stop sample
    clear_obs();
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b1, -1, -1);
    send_byte(8'h05, 1'b1, 154, -1);
    repeat (10) tick();
    check("full_pop_ovr", ov_cnt, 0);
    check("full_pop_count", rx_q.size(), 5);
    check("full_pop_data", pack_rx(), {8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

    // Reset during data bit 3 of 0x3C aborts the frame silently
    clear_obs();
    i_ready = 1'b1;
    send_byte(8'h3C, 1'b1, -1, 70);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_valid", o_valid, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    check("rst_mid_nopush", rx_q.size(), 0);
    check("rst_mid_noerr", fe_cnt + ov_cnt, 0);
    send_byte(8'h3C, 1'b1, -1, -1);
    repeat (4) tick();
    check("rst_mid_resume", pack_rx(), {8'h3C, 8'hEE, 8'hEE, 8'hEE, 8'hEE});
    check("rst_mid_err", fe_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
